// File: rtl/serial_cmd_receiver.sv
// serial_cmd_receiver: SUMP command receiver. A 2-FF rx synchroniser, an oversampled UART byte
// receiver and a short/long command assembler, with framing, timeout and overrun reporting.
//
// state        | meaning
// B_IDLE       | line idle, waiting for synced rx low
// B_START      | half-bit wait, then confirm the start bit
// B_DATA       | sampling 8 data bits, LSB first
// B_STOP       | sampling the stop bit
// B_WAIT_HIGH  | stop bit was low, waiting for the line to return high
// A_WAIT_OP    | expecting an opcode byte
// A_WAIT_DATA  | collecting the payload bytes of a long command
module serial_cmd_receiver #(
  parameter int         FREQ         = 100000000,
  parameter int         RATE         = 115200,
  parameter int         OVERSAMPLE   = 16,
  parameter int         DATA_BYTES   = 4,
  parameter logic [7:0] LONG_MASK    = 8'h80,
  parameter int         TIMEOUT_BITS = 20
) (
  input  logic                    clock,
  input  logic                    extReset_n,
  input  logic                    rx,
  input  logic                    transmitting,
  output logic [7:0]              op,
  output logic [8*DATA_BYTES-1:0] data,
  output logic                    execute,
  output logic                    busy,
  output logic                    frame_err,
  output logic                    timeout_err,
  output logic                    overrun
);

  localparam int DIVISOR  = FREQ / (RATE * OVERSAMPLE);
  localparam int DIV_W    = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int SMP_W    = $clog2(OVERSAMPLE);
  localparam int CNT_W    = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int TO_TICKS = (TIMEOUT_BITS > 0) ? TIMEOUT_BITS * OVERSAMPLE : 1;
  localparam int TO_W     = (TO_TICKS > 1) ? $clog2(TO_TICKS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_BYTES - 1);

  if (DIVISOR < 1) begin : g_div_chk
    $error("serial_cmd_receiver: FREQ/(RATE*OVERSAMPLE) must be at least 1");
  end
  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
    $error("serial_cmd_receiver: OVERSAMPLE must be even and >= 4");
  end
  if (DATA_BYTES < 1 || DATA_BYTES > 8) begin : g_db_chk
    $error("serial_cmd_receiver: DATA_BYTES must be 1..8");
  end

  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP, B_WAIT_HIGH} byte_state_t;
  typedef enum logic {A_WAIT_OP, A_WAIT_DATA} asm_state_t;

  byte_state_t             b_state;
  asm_state_t              a_state;
  logic                    rx_meta, rx_sync;
  logic [DIV_W-1:0]        div_cnt;
  logic                    tick, start_entry;
  logic [SMP_W-1:0]        samp_cnt;
  logic [2:0]              bit_cnt;
  logic [7:0]              rx_byte;
  logic                    byte_valid;
  logic [TO_W-1:0]         to_cnt;
  logic                    timeout_hit;
  logic [CNT_W-1:0]        byte_cnt;
  logic [7:0]              op_next, asm_op;
  logic [8*DATA_BYTES-1:0] data_next, asm_data;
  logic                    pending, asm_long, asm_done;

  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  assign start_entry = (b_state == B_IDLE) && !rx_sync;
  assign tick        = (div_cnt == '0);

  // Divider restarts on the start edge so sample points sit at fixed offsets from it.
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n)              div_cnt <= '0;
    else if (start_entry || tick) div_cnt <= DIV_W'(DIVISOR - 1);
    else                          div_cnt <= div_cnt - 1'b1;
  end

  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      b_state    <= B_IDLE;
      samp_cnt   <= '0;
      bit_cnt    <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (b_state)
        B_IDLE: if (!rx_sync) begin
          b_state  <= B_START;
          samp_cnt <= SMP_W'(OVERSAMPLE / 2 - 1);
        end
        B_START: if (tick) begin
          if (samp_cnt != '0) samp_cnt <= samp_cnt - 1'b1;
          else if (rx_sync)   b_state  <= B_IDLE;
          else begin
            b_state  <= B_DATA;
            samp_cnt <= SMP_W'(OVERSAMPLE - 1);
            bit_cnt  <= '0;
          end
        end
        B_DATA: if (tick) begin
          if (samp_cnt != '0) samp_cnt <= samp_cnt - 1'b1;
          else begin
            rx_byte  <= {rx_sync, rx_byte[7:1]};
            samp_cnt <= SMP_W'(OVERSAMPLE - 1);
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) b_state <= B_STOP;
          end
        end
        B_STOP: if (tick) begin
          if (samp_cnt != '0) samp_cnt <= samp_cnt - 1'b1;
          else if (rx_sync) begin
            byte_valid <= 1'b1;
            b_state    <= B_IDLE;
          end else begin
            frame_err <= 1'b1;
            b_state   <= B_WAIT_HIGH;
          end
        end
        B_WAIT_HIGH: if (rx_sync) b_state <= B_IDLE;
        default: b_state <= B_IDLE;
      endcase
    end
  end

  // Inter-byte timer: held loaded outside WAIT_DATA, restarted by each stop or start edge.
  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) to_cnt <= '0;
    else if (start_entry || byte_valid || a_state != A_WAIT_DATA) to_cnt <= TO_W'(TO_TICKS - 1);
    else if (tick && to_cnt != '0) to_cnt <= to_cnt - 1'b1;
  end

  assign timeout_hit = (TIMEOUT_BITS != 0) && (a_state == A_WAIT_DATA) && tick && (to_cnt == '0);

  always_comb begin
    asm_op   = op_next;
    asm_data = data_next;
    if (a_state == A_WAIT_OP) begin
      asm_op   = rx_byte;
      asm_data = '0;
    end else begin
      asm_data[8*int'(byte_cnt) +: 8] = rx_byte;
    end
  end

  assign asm_long = (rx_byte & LONG_MASK) != 8'h00;
  assign asm_done = byte_valid && !pending &&
                    (((a_state == A_WAIT_OP) && !asm_long) ||
                     ((a_state == A_WAIT_DATA) && (byte_cnt == LAST)));

  always_ff @(posedge clock or negedge extReset_n) begin
    if (!extReset_n) begin
      a_state     <= A_WAIT_OP;
      byte_cnt    <= '0;
      op_next     <= '0;
      data_next   <= '0;
      pending     <= 1'b0;
      op          <= '0;
      data        <= '0;
      execute     <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      execute     <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
      if (pending && !transmitting) begin
        op      <= op_next;
        data    <= data_next;
        execute <= 1'b1;
        pending <= 1'b0;
      end
      if (frame_err) begin
        a_state  <= A_WAIT_OP;
        busy     <= 1'b0;
        byte_cnt <= '0;
      end else if (byte_valid && pending) begin
        overrun <= 1'b1;
      end else if (byte_valid) begin
        op_next   <= asm_op;
        data_next <= asm_data;
        if (a_state == A_WAIT_OP) begin
          if (asm_long) begin
            a_state  <= A_WAIT_DATA;
            busy     <= 1'b1;
            byte_cnt <= '0;
          end
        end else if (byte_cnt == LAST) begin
          a_state <= A_WAIT_OP;
          busy    <= 1'b0;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
        if (asm_done) begin
          if (transmitting) pending <= 1'b1;
          else begin
            op      <= asm_op;
            data    <= asm_data;
            execute <= 1'b1;
          end
        end
      end else if (timeout_hit) begin
        timeout_err <= 1'b1;
        a_state     <= A_WAIT_OP;
        busy        <= 1'b0;
        byte_cnt    <= '0;
      end
    end
  end

endmodule
